l2_sdp_rd_ctrl: RTL and testbench



---
 rtl/l2_sdp_pkg.sv | 29 ++
 rtl/l2_sdp_rsp_fifo.sv | 57 +++++
 rtl/l2_sdp_rd_ctrl.sv | 125 ++++++++++++
 tb/tb_l2_sdp_rd_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_sdp_pkg.sv
// Shared constants, response record and byte-strobe merge helper for the
// L2 simple-dual-port data array read path.
package l2_sdp_pkg;

  localparam int L2_SDP_AW    = 10;
  localparam int L2_SDP_DW    = 256;
  localparam int L2_SDP_BW    = 32;
  localparam int L2_SDP_TAG_W = 4;

  typedef struct packed {
    logic [L2_SDP_DW-1:0]    data;
    logic [L2_SDP_TAG_W-1:0] tag;
  } l2_sdp_rsp_t;

  // Bytes whose strobe bit is set come from new_data, all others from old_data.
  function automatic logic [L2_SDP_DW-1:0] l2_sdp_merge(
    input logic [L2_SDP_DW-1:0] old_data,
    input logic [L2_SDP_DW-1:0] new_data,
    input logic [L2_SDP_BW-1:0] strb
  );
    logic [L2_SDP_DW-1:0] res;
    res = old_data;
    for (int b = 0; b < L2_SDP_BW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_sdp_rsp_fifo.sv
// Small synchronous FIFO of read responses with an occupancy count; the head
// entry is presented on data_o and reads as zero while the FIFO is empty.
module l2_sdp_rsp_fifo
  import l2_sdp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  l2_sdp_rsp_t            data_i,
  input  logic                   pop_i,
  output l2_sdp_rsp_t            data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  l2_sdp_rsp_t   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (do_pop) rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: its contents are only visible while count_q != 0.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/l2_sdp_rd_ctrl.sv
// Read-side controller for the 1024x256 L2 SDP array: issues reads, captures
// data one cycle later and returns it through a credit-protected output FIFO.
// Define L2_SDP_RD_FWD_EN to forward same-cycle colliding writes (write-first).
module l2_sdp_rd_ctrl
  import l2_sdp_pkg::*;
#(
  parameter int AW        = L2_SDP_AW,
  parameter int DW        = L2_SDP_DW,
  parameter int TAG_W     = L2_SDP_TAG_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_vld_i,
  output logic              req_rdy_o,
  input  logic [AW-1:0]     req_addr_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              ram_re_o,
  output logic [AW-1:0]     ram_raddr_o,
  input  logic [DW-1:0]     ram_rdata_i,
  input  logic              wr_we_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic [DW/8-1:0]   wr_strob_i,
  output logic              rsp_vld_o,
  input  logic              rsp_rdy_i,
  output logic [DW-1:0]     rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic             rdy_q;
  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    occupancy;
  logic             fifo_empty;
  logic             pop;
  logic             issue;
  logic [DW-1:0]    cap_data;
  l2_sdp_rsp_t      push_rsp;
  l2_sdp_rsp_t      head_rsp;

  // Every issued read owns a FIFO slot until popped, so capture never overflows.
  assign pop         = rsp_vld_o & rsp_rdy_i;
  assign occupancy   = fifo_count + CW'(inflight_q) - CW'(pop);
  assign req_rdy_o   = rdy_q & (occupancy < CW'(OUT_DEPTH));
  assign issue       = req_vld_i & req_rdy_o;
  assign ram_re_o    = issue;
  assign ram_raddr_o = rdy_q ? req_addr_i : '0;

  always_comb begin
    inflight_d = issue;
    tag_d      = issue ? req_tag_i : tag_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q      <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      rdy_q      <= 1'b1;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

`ifdef L2_SDP_RD_FWD_EN
  logic            fwd_hit_q, fwd_hit_d;
  logic [DW-1:0]   fwd_data_q, fwd_data_d;
  logic [DW/8-1:0] fwd_strb_q, fwd_strb_d;

  always_comb begin
    fwd_hit_d  = issue & wr_we_i & (wr_addr_i == ram_raddr_o);
    fwd_data_d = fwd_data_q;
    fwd_strb_d = fwd_strb_q;
    if (fwd_hit_d) begin
      fwd_data_d = wr_data_i;
      fwd_strb_d = wr_strob_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      fwd_strb_q <= fwd_strb_d;
    end
  end

  assign cap_data = fwd_hit_q ? l2_sdp_merge(ram_rdata_i, fwd_data_q, fwd_strb_q)
                              : ram_rdata_i;
`else
  logic wr_unused;
  assign wr_unused = ^{wr_we_i, wr_addr_i, wr_data_i, wr_strob_i};
  assign cap_data  = ram_rdata_i;
`endif

  assign push_rsp.data = cap_data;
  assign push_rsp.tag  = tag_q;

  l2_sdp_rsp_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (push_rsp),
    .pop_i   (pop),
    .data_o  (head_rsp),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_vld_o  = ~fifo_empty;
  assign rsp_data_o = head_rsp.data;
  assign rsp_tag_o  = head_rsp.tag;

endmodule

// File: tb/tb_l2_sdp_rd_ctrl.sv
// Self-checking bench for l2_sdp_rd_ctrl: a read-first RAM model plus a
// transaction-level reference model (queue of outstanding responses).
module tb_l2_sdp_rd_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 256;
  localparam int TW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_vld_i = 1'b0;
  logic          req_rdy_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [TW-1:0] req_tag_i = '0;
  logic          ram_re_o;
  logic [AW-1:0] ram_raddr_o;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          wr_we_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic [BW-1:0] wr_strob_i = '0;
  logic          rsp_vld_o;
  logic          rsp_rdy_i = 1'b0;
  logic [DW-1:0] rsp_data_o;
  logic [TW-1:0] rsp_tag_o;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            readyCyc;
  } expRsp_t;

  logic [DW-1:0] mem [1024];
  expRsp_t       expQ[$];
  int            cycleNum = 0;
  bit            rdyEnable = 1'b0;
  int            assertCount = 0;
  int            failCount = 0;

  always #5 clk_i = ~clk_i;

  l2_sdp_rd_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_vld_i   (req_vld_i),
    .req_rdy_o   (req_rdy_o),
    .req_addr_i  (req_addr_i),
    .req_tag_i   (req_tag_i),
    .ram_re_o    (ram_re_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .wr_we_i     (wr_we_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_strob_i  (wr_strob_i),
    .rsp_vld_o   (rsp_vld_o),
    .rsp_rdy_i   (rsp_rdy_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o)
  );

  // Synchronous read-first array: data appears the cycle after the read enable.
  always @(posedge clk_i) begin
    if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
  end

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldD,
                                               input logic [DW-1:0] newD,
                                               input logic [BW-1:0] strb);
    logic [DW-1:0] r;
    for (int b = 0; b < BW; b++) r[b*8 +: 8] = strb[b] ? newD[b*8 +: 8] : oldD[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit vld, input logic [AW-1:0] addr,
                               input logic [TW-1:0] tag, input bit rdy,
                               input bit we, input logic [AW-1:0] waddr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] wstrb);
    bit            expVld, expRdy, expRe, popExp;
    logic [DW-1:0] d;
    @(negedge clk_i);
    req_vld_i  = vld;
    req_addr_i = addr;
    req_tag_i  = tag;
    rsp_rdy_i  = rdy;
    wr_we_i    = we;
    wr_addr_i  = waddr;
    wr_data_i  = wdata;
    wr_strob_i = wstrb;
    #1;
    expVld = (expQ.size() > 0) && (expQ[0].readyCyc <= cycleNum);
    popExp = expVld && rdy;
    expRdy = rdyEnable && ((expQ.size() - (popExp ? 1 : 0)) < DEPTH);
    expRe  = vld && expRdy;
    checkOutput("req_rdy", DW'(req_rdy_o), DW'(expRdy));
    checkOutput("ram_re", DW'(ram_re_o), DW'(expRe));
    if (expRe) checkOutput("ram_raddr", DW'(ram_raddr_o), DW'(addr));
    checkOutput("rsp_vld", DW'(rsp_vld_o), DW'(expVld));
    if (expVld) begin
      checkOutput("rsp_data", rsp_data_o, expQ[0].data);
      checkOutput("rsp_tag", DW'(rsp_tag_o), DW'(expQ[0].tag));
    end
    if (popExp) void'(expQ.pop_front());
    if (expRe) begin
      d = mem[addr];
`ifdef L2_SDP_RD_FWD_EN
      if (we && (waddr == addr)) d = mergeBytes(d, wdata, wstrb);
`endif
      expQ.push_back('{data: d, tag: tag, readyCyc: cycleNum + 2});
    end
    cycleNum++;
    @(posedge clk_i);
    #1;
    if (we) mem[waddr] = mergeBytes(mem[waddr], wdata, wstrb);
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, rdy, 1'b0, '0, '0, '0);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases on a falling edge.
  task automatic resetDut();
    #2;
    rst_ni     = 1'b0;
    req_vld_i  = 1'b1;
    req_addr_i = 10'h155;
    req_tag_i  = 4'h9;
    rsp_rdy_i  = 1'b0;
    wr_we_i    = 1'b0;
    rdyEnable  = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_req_rdy", DW'(req_rdy_o), '0);
    checkOutput("rst_ram_re", DW'(ram_re_o), '0);
    checkOutput("rst_ram_raddr", DW'(ram_raddr_o), '0);
    checkOutput("rst_rsp_vld", DW'(rsp_vld_o), '0);
    checkOutput("rst_rsp_data", rsp_data_o, '0);
    checkOutput("rst_rsp_tag", DW'(rsp_tag_o), '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("rel_req_rdy", DW'(req_rdy_o), '0);
    checkOutput("rel_ram_re", DW'(ram_re_o), '0);
    checkOutput("rel_rsp_vld", DW'(rsp_vld_o), '0);
    rdyEnable = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] aaData;
    aaData = {32{8'hAA}};
    for (int a = 0; a < 1024; a++) mem[a] = randData();

    resetDut();

    applyStimulus(1'b1, 10'h005, 4'd3, 1'b1, 1'b0, '0, '0, '0);
    idleCycles(3, 1'b1);

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, AW'(10'h3F0 + i), TW'(i), 1'b1, 1'b0, '0, '0, '0);
    idleCycles(3, 1'b1);

    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, AW'($urandom_range(0, 1023)), TW'(i + 4), 1'b0, 1'b0, '0, '0, '0);
    idleCycles(6, 1'b1);

    applyStimulus(1'b1, 10'h200, 4'd5, 1'b1, 1'b1, 10'h200, aaData, 32'h0000000F);
    applyStimulus(1'b1, 10'h200, 4'd6, 1'b1, 1'b0, '0, '0, '0);
    idleCycles(3, 1'b1);

    for (int c = 0; c < 10000; c++)
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), TW'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    AW'($urandom_range(0, 7)), randData(), BW'($urandom));
    idleCycles(4, 1'b1);

    applyStimulus(1'b1, 10'h010, 4'hA, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 10'h011, 4'hB, 1'b0, 1'b0, '0, '0, '0);
    resetDut();
    idleCycles(4, 1'b1);
    applyStimulus(1'b1, 10'h012, 4'hC, 1'b1, 1'b0, '0, '0, '0);
    idleCycles(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
